mips_ctrl_pipe: RTL

Parametrised pipelined control unit for the five-stage MIPS core. It decodes the ID-stage opcode/funct into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB registers, with bubble insertion on flush and a global freeze on hold. It optionally decodes an extended instruction set and a wider ALU-control encoding. It also keeps a sticky illegal-instruction flag and a saturating retired-instruction counter.

---
 rtl/mips_ctrl_pkg.sv | 43 ++++
 rtl/mips_ctrl_pipe_if.sv | 57 +++++
 rtl/mips_ctrl_decode.sv | 102 ++++++++++
 rtl/mips_ctrl_pipe.sv | 90 +++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared opcode/funct encodings, ALU-control codes and the control bundle
// carried from ID into EX for the five-stage MIPS control pipeline.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Codes are held at 4 bits; the top level zero-extends or trims to ALUCTRL_W.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1000;
  localparam logic [3:0] ALU_NOR = 4'b1001;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regdst;
    logic       zeroext;
    logic [3:0] alucontrol;
  } ctrl_bundle_t;

endpackage

// File: rtl/mips_ctrl_pipe_if.sv
// ID-stage inputs and per-stage control outputs of the MIPS control pipeline.
interface mips_ctrl_pipe_if #(
  parameter int ALUCTRL_W = 3,
  parameter int CNT_W     = 32
);
  logic                 valid_d;
  logic [5:0]           op;
  logic [5:0]           funct;
  logic                 flush_e;
  logic                 hold;

  logic                 branch_d;
  logic                 branch_ne_d;
  logic                 jump_d;
  logic                 illegal_d;

  logic                 valid_e;
  logic                 regwrite_e;
  logic                 memtoreg_e;
  logic                 memwrite_e;
  logic                 alusrc_e;
  logic                 regdst_e;
  logic                 zeroext_e;
  logic [ALUCTRL_W-1:0] alucontrol_e;

  logic                 valid_m;
  logic                 regwrite_m;
  logic                 memtoreg_m;
  logic                 memwrite_m;

  logic                 valid_w;
  logic                 regwrite_w;
  logic                 memtoreg_w;

  logic                 illegal_seen;
  logic [CNT_W-1:0]     retired;

  modport master (
    output valid_d, op, funct, flush_e, hold,
    input  branch_d, branch_ne_d, jump_d, illegal_d,
    input  valid_e, regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e,
           zeroext_e, alucontrol_e,
    input  valid_m, regwrite_m, memtoreg_m, memwrite_m,
    input  valid_w, regwrite_w, memtoreg_w,
    input  illegal_seen, retired
  );

  modport slave (
    input  valid_d, op, funct, flush_e, hold,
    output branch_d, branch_ne_d, jump_d, illegal_d,
    output valid_e, regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e,
           zeroext_e, alucontrol_e,
    output valid_m, regwrite_m, memtoreg_m, memwrite_m,
    output valid_w, regwrite_w, memtoreg_w,
    output illegal_seen, retired
  );
endinterface

// File: rtl/mips_ctrl_decode.sv
// Combinational ID-stage decoder: op/funct to control bundle plus branch,
// jump and illegal flags. Unsupported encodings collapse to a NOP bundle.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int EXT_OPS   = 0
) (
  input  logic         valid_d,
  input  logic [5:0]   op,
  input  logic [5:0]   funct,
  output ctrl_bundle_t ctrl,
  output logic         branch,
  output logic         branch_ne,
  output logic         jump,
  output logic         illegal
);

  localparam bit WIDE_ALU = (ALUCTRL_W >= 4);
  localparam bit EXT_EN   = (EXT_OPS != 0);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    ctrl      = '0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    jump      = 1'b0;
    illegal   = 1'b0;

    if (valid_d) begin
      case (op)
        OP_RTYPE: begin
          ctrl.regwrite = 1'b1;
          ctrl.regdst   = 1'b1;
          case (funct)
            FN_ADD:  ctrl.alucontrol = ALU_ADD;
            FN_SUB:  ctrl.alucontrol = ALU_SUB;
            FN_AND:  ctrl.alucontrol = ALU_AND;
            FN_OR:   ctrl.alucontrol = ALU_OR;
            FN_SLT:  ctrl.alucontrol = ALU_SLT;
            FN_XOR:  if (WIDE_ALU) ctrl.alucontrol = ALU_XOR; else illegal = 1'b1;
            FN_NOR:  if (WIDE_ALU) ctrl.alucontrol = ALU_NOR; else illegal = 1'b1;
            default: illegal = 1'b1;
          endcase
        end
        OP_LW: begin
          ctrl.regwrite   = 1'b1;
          ctrl.alusrc     = 1'b1;
          ctrl.memtoreg   = 1'b1;
          ctrl.alucontrol = ALU_ADD;
        end
        OP_SW: begin
          ctrl.memwrite   = 1'b1;
          ctrl.alusrc     = 1'b1;
          ctrl.alucontrol = ALU_ADD;
        end
        OP_BEQ: begin
          branch          = 1'b1;
          ctrl.alucontrol = ALU_SUB;
        end
        OP_ADDI: begin
          ctrl.regwrite   = 1'b1;
          ctrl.alusrc     = 1'b1;
          ctrl.alucontrol = ALU_ADD;
        end
        OP_J: jump = 1'b1;
        OP_BNE: begin
          if (EXT_EN) begin
            branch_ne       = 1'b1;
            ctrl.alucontrol = ALU_SUB;
          end else illegal = 1'b1;
        end
        OP_ANDI, OP_ORI: begin
          if (EXT_EN) begin
            ctrl.regwrite   = 1'b1;
            ctrl.alusrc     = 1'b1;
            ctrl.zeroext    = 1'b1;
            ctrl.alucontrol = (op == OP_ANDI) ? ALU_AND : ALU_OR;
          end else illegal = 1'b1;
        end
        OP_SLTI: begin
          if (EXT_EN) begin
            ctrl.regwrite   = 1'b1;
            ctrl.alusrc     = 1'b1;
            ctrl.alucontrol = ALU_SLT;
          end else illegal = 1'b1;
        end
        default: illegal = 1'b1;
      endcase

      // An illegal encoding still travels down the pipe, but as a pure NOP.
      if (illegal) begin
        ctrl      = '0;
        branch    = 1'b0;
        branch_ne = 1'b0;
        jump      = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mips_ctrl_pipe.sv
// Pipelined MIPS control unit: ID decode feeding ID/EX, EX/MEM and MEM/WB
// control registers, with flush bubbles, global hold, sticky illegal flag
// and a saturating retired-instruction counter.
module mips_ctrl_pipe
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int EXT_OPS   = 0,
  parameter int CNT_W     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  mips_ctrl_pipe_if.slave bus
);

  ctrl_bundle_t     ctrl_d;
  logic             illegal_d;

  ctrl_bundle_t     ex_q;
  logic             ex_valid_q;
  logic             mem_valid_q, mem_regwrite_q, mem_memtoreg_q, mem_memwrite_q;
  logic             wb_valid_q, wb_regwrite_q, wb_memtoreg_q;
  logic             illegal_seen_q;
  logic [CNT_W-1:0] retired_q;

  mips_ctrl_decode #(
    .ALUCTRL_W (ALUCTRL_W),
    .EXT_OPS   (EXT_OPS)
  ) u_decode (
    .valid_d   (bus.valid_d),
    .op        (bus.op),
    .funct     (bus.funct),
    .ctrl      (ctrl_d),
    .branch    (bus.branch_d),
    .branch_ne (bus.branch_ne_d),
    .jump      (bus.jump_d),
    .illegal   (illegal_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q           <= '0;
      ex_valid_q     <= 1'b0;
      mem_valid_q    <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_memtoreg_q <= 1'b0;
      mem_memwrite_q <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_memtoreg_q  <= 1'b0;
      illegal_seen_q <= 1'b0;
      retired_q      <= '0;
    end else if (!bus.hold) begin
      // NOTE: non-blocking assignments let each stage capture the previous
      // stage's pre-edge value, which is what makes this a shift pipeline.
      ex_valid_q     <= bus.valid_d && !bus.flush_e;
      ex_q           <= bus.flush_e ? '0 : ctrl_d;
      mem_valid_q    <= ex_valid_q;
      mem_regwrite_q <= ex_q.regwrite;
      mem_memtoreg_q <= ex_q.memtoreg;
      mem_memwrite_q <= ex_q.memwrite;
      wb_valid_q     <= mem_valid_q;
      wb_regwrite_q  <= mem_regwrite_q;
      wb_memtoreg_q  <= mem_memtoreg_q;
      // A flushed illegal instruction is still recorded.
      if (illegal_d) illegal_seen_q <= 1'b1;
      if (wb_valid_q && (retired_q != '1)) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.illegal_d    = illegal_d;
  assign bus.valid_e      = ex_valid_q;
  assign bus.regwrite_e   = ex_q.regwrite;
  assign bus.memtoreg_e   = ex_q.memtoreg;
  assign bus.memwrite_e   = ex_q.memwrite;
  assign bus.alusrc_e     = ex_q.alusrc;
  assign bus.regdst_e     = ex_q.regdst;
  assign bus.zeroext_e    = ex_q.zeroext;
  assign bus.alucontrol_e = ALUCTRL_W'(ex_q.alucontrol);
  assign bus.valid_m      = mem_valid_q;
  assign bus.regwrite_m   = mem_regwrite_q;
  assign bus.memtoreg_m   = mem_memtoreg_q;
  assign bus.memwrite_m   = mem_memwrite_q;
  assign bus.valid_w      = wb_valid_q;
  assign bus.regwrite_w   = wb_regwrite_q;
  assign bus.memtoreg_w   = wb_memtoreg_q;
  assign bus.illegal_seen = illegal_seen_q;
  assign bus.retired      = retired_q;

endmodule
